// File: rtl/bin_to_bcd_iter.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_iter
//   Iterative binary -> packed BCD converter (double-dabble, one bit per
//   cycle, MSB first). A value is accepted on a valid/ready handshake. It is
//   converted over ANCHO_BIN cycles. The result is then held until the
//   consumer takes it.
//
// Parameters
//   ANCHO_BIN  binary input width (4..32)
//   DIGITOS    number of BCD output digits (1..10)
//   CON_SIGNO  0 = unsigned input, 1 = two's-complement input
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   binario    value to convert, captured on accept
//   in_valid   binario is valid
//   in_ready   block can accept a value (idle)
//   bcd        packed BCD result, least significant digit in [3:0]
//   signo      result is negative (always 0 when CON_SIGNO = 0)
//   desborde   magnitude exceeds 10^DIGITOS - 1
//   out_valid  bcd / signo / desborde hold a result
//   out_ready  consumer takes the result
// ---------------------------------------------------------------------------
module bin_to_bcd_iter #(
    parameter int ANCHO_BIN = 12,
    parameter int DIGITOS   = 4,
    parameter int CON_SIGNO = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ANCHO_BIN-1:0]   binario,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [4*DIGITOS-1:0]   bcd,
    output logic                   signo,
    output logic                   desborde,
    output logic                   out_valid,
    input  logic                   out_ready
);

    // The shift register carries one extra guard digit above the visible
    // ones. Anything that lands there means the value did not fit.
    localparam int BW = 4 * (DIGITOS + 1);
    localparam int CW = $clog2(ANCHO_BIN + 1);
    localparam logic [CW-1:0] ULTIMO = CW'(ANCHO_BIN - 1);

    typedef enum logic [1:0] {
        REPOSO    = 2'd0,
        CONVIERTE = 2'd1,
        LISTO     = 2'd2
    } estado_t;

    estado_t               estado_q;
    logic [ANCHO_BIN-1:0]  mag_q;
    logic [CW-1:0]         cnt_q;
    logic [BW-1:0]         bcd_q;
    logic                  signo_q;
    logic                  desb_q;
    logic                  out_valid_q;
    logic                  in_ready_q;

    // ---------------------------------------------------------------------
    // Input magnitude. The negation is done ANCHO_BIN bits wide. The most
    // negative value therefore maps onto itself. Read as unsigned, that is
    // exactly 2^(ANCHO_BIN-1), the correct magnitude.
    // ---------------------------------------------------------------------
    logic                  neg_d;
    logic [ANCHO_BIN-1:0]  mag_d;

    always_comb begin
        neg_d = (CON_SIGNO != 0) && binario[ANCHO_BIN-1];
        mag_d = neg_d ? ({ANCHO_BIN{1'b0}} - binario) : binario;
    end

    // ---------------------------------------------------------------------
    // One double-dabble step. Every digit >= 5 (the guard digit included)
    // gets +3. The vector then shifts left, and the magnitude MSB enters
    // at bit 0.
    // ---------------------------------------------------------------------
    logic [BW-1:0] ajus_d;
    logic [BW-1:0] bcd_d;
    logic          sale_d;
    logic          desb_paso_d;

    always_comb begin
        ajus_d = bcd_q;
        for (int d = 0; d < DIGITOS + 1; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5) begin
                ajus_d[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
            end
        end
        bcd_d       = {ajus_d[BW-2:0], mag_q[ANCHO_BIN-1]};
        sale_d      = ajus_d[BW-1];
        // Overflow if a 1 falls off the top of the guard digit, or if the
        // guard digit holds anything after the shift.
        desb_paso_d = sale_d || (bcd_d[BW-1 -: 4] != 4'd0);
    end

    // ---------------------------------------------------------------------
    // Control FSM with registered handshake outputs.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q    <= REPOSO;
            mag_q       <= '0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            signo_q     <= 1'b0;
            desb_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            case (estado_q)
                REPOSO: begin
                    // in_ready is held low through reset. It comes up on the
                    // first edge after release.
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        mag_q      <= mag_d;
                        signo_q    <= neg_d;
                        bcd_q      <= '0;
                        cnt_q      <= '0;
                        desb_q     <= 1'b0;
                        in_ready_q <= 1'b0;
                        estado_q   <= CONVIERTE;
                    end
                end

                CONVIERTE: begin
                    bcd_q  <= bcd_d;
                    mag_q  <= mag_q << 1;
                    desb_q <= desb_q | desb_paso_d;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == ULTIMO) begin
                        out_valid_q <= 1'b1;
                        estado_q    <= LISTO;
                    end
                end

                LISTO: begin
                    // The result stays frozen until the consumer takes it.
                    // There is no bypass: in_ready rises only after this edge.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        estado_q    <= REPOSO;
                    end
                end

                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b0;
                    estado_q    <= REPOSO;
                end
            endcase
        end
    end

    // On overflow, the visible digits are the low DIGITOS digits of the
    // full result. The guard digit is not shown.
    assign bcd       = bcd_q[4*DIGITOS-1:0];
    assign signo     = signo_q;
    assign desborde  = desb_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_bin_to_bcd_iter.sv
// ---------------------------------------------------------------------------
// tb_bin_to_bcd_iter
//   Directed bench for bin_to_bcd_iter. Three instances are used:
//     u0 : defaults (12 bit unsigned, 4 digits)
//     u1 : 12 bit two's-complement, 4 digits
//     u2 : 12 bit unsigned, 3 digits (overflow cases)
//   Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_bin_to_bcd_iter;

    logic        clk;
    logic        rst_n;
    logic [11:0] bin [3];
    logic [2:0]  iv;
    logic [2:0]  rdy;
    logic [2:0]  ov;
    logic [2:0]  ordy;
    logic [2:0]  sg;
    logic [2:0]  ds;
    logic [15:0] bcd0;
    logic [15:0] bcd1;
    logic [11:0] bcd2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc_cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin_to_bcd_iter #(.ANCHO_BIN(12), .DIGITOS(4), .CON_SIGNO(0)) u0 (
        .clk(clk), .rst_n(rst_n), .binario(bin[0]), .in_valid(iv[0]),
        .in_ready(rdy[0]), .bcd(bcd0), .signo(sg[0]), .desborde(ds[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]));

    bin_to_bcd_iter #(.ANCHO_BIN(12), .DIGITOS(4), .CON_SIGNO(1)) u1 (
        .clk(clk), .rst_n(rst_n), .binario(bin[1]), .in_valid(iv[1]),
        .in_ready(rdy[1]), .bcd(bcd1), .signo(sg[1]), .desborde(ds[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]));

    bin_to_bcd_iter #(.ANCHO_BIN(12), .DIGITOS(3), .CON_SIGNO(0)) u2 (
        .clk(clk), .rst_n(rst_n), .binario(bin[2]), .in_valid(iv[2]),
        .in_ready(rdy[2]), .bcd(bcd2), .signo(sg[2]), .desborde(ds[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] bcd_of(input int s);
        case (s)
            0:       return bcd0;
            1:       return bcd1;
            default: return {4'h0, bcd2};
        endcase
    endfunction

    // Present v to instance s, wait for the accept, then wait for out_valid.
    // The accept cycle is recorded in acc_cyc.
    task automatic run(input int s, input logic [11:0] v, output int lat);
        bit acc;
        acc    = 1'b0;
        bin[s] = v;
        iv[s]  = 1'b1;
        for (int k = 0; k < 40 && !acc; k++) begin
            acc = rdy[s];
            @(posedge clk); #1;
        end
        iv[s]   = 1'b0;
        acc_cyc = cyc;
        chk("accept", 32'(acc), 32'd1);
        lat = 0;
        while (!ov[s] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, 12);
    endtask

    // Release the held result and check the handshake comes back.
    task automatic rel(input int s);
        ordy[s] = 1'b1;
        @(posedge clk); #1;
        chk("rel_out_valid", 32'(ov[s]), 32'd0);
        chk("rel_in_ready",  32'(rdy[s]), 32'd1);
    endtask

    // Run one full conversion and check the result.
    task automatic conv(input int s, input logic [11:0] v, input logic [15:0] eb,
                        input logic esg, input logic eds, input string tag);
        int lat;
        run(s, v, lat);
        chk({tag, "_bcd"},   32'(bcd_of(s)), 32'(eb));
        chk({tag, "_signo"}, 32'(sg[s]),     32'(esg));
        chk({tag, "_desb"},  32'(ds[s]),     32'(eds));
        rel(s);
    endtask

    initial begin
        int lat;
        int first;
        bit acc;
        rst_n = 1'b0;
        iv    = '0;
        ordy  = '0;
        for (int i = 0; i < 3; i++) bin[i] = '0;

        // State while reset is held.
        #23;
        chk("rst_in_ready",  32'(rdy), 32'd0);
        chk("rst_out_valid", 32'(ov),  32'd0);
        chk("rst_bcd0",      32'(bcd0), 32'd0);
        chk("rst_desb",      32'(ds),  32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", 32'(rdy), 32'h7);

        // Unsigned, default parameters.
        conv(0, 12'd4095, 16'h4095, 1'b0, 1'b0, "u4095");
        conv(0, 12'd1234, 16'h1234, 1'b0, 1'b0, "u1234");
        conv(0, 12'h800,  16'h2048, 1'b0, 1'b0, "u2048");

        // Back-to-back with out_ready held high: 0 then 1.
        ordy[0] = 1'b1;
        run(0, 12'd0, lat);
        first = acc_cyc;
        chk("b2b0_bcd", 32'(bcd0), 32'h0000);
        @(posedge clk); #1;
        chk("b2b_ready", 32'(rdy[0]), 32'd1);
        run(0, 12'd1, lat);
        chk("b2b1_bcd", 32'(bcd0), 32'h0001);
        chk("b2b_spacing", acc_cyc - first, 14);
        rel(0);
        ordy[0] = 1'b0;

        // Two's complement.
        conv(1, 12'h800, 16'h2048, 1'b1, 1'b0, "s800");
        conv(1, 12'hFFF, 16'h0001, 1'b1, 1'b0, "sFFF");
        conv(1, 12'h7FF, 16'h2047, 1'b0, 1'b0, "s7FF");
        conv(1, 12'h000, 16'h0000, 1'b0, 1'b0, "s000");

        // Three digits: overflow and edge of range.
        conv(2, 12'd1000, 16'h0000, 1'b0, 1'b1, "d1000");
        conv(2, 12'd999,  16'h0999, 1'b0, 1'b0, "d999");
        conv(2, 12'd4095, 16'h0095, 1'b0, 1'b1, "d4095");

        // Held result: out_ready low, in_valid toggling for 20 cycles.
        run(0, 12'd567, lat);
        for (int i = 0; i < 20; i++) begin
            iv[0]  = ~iv[0];
            bin[0] = 12'(i * 37);
            @(posedge clk); #1;
            chk("hold_bcd",   32'(bcd0),   32'h0567);
            chk("hold_ov",    32'(ov[0]),  32'd1);
            chk("hold_ready", 32'(rdy[0]), 32'd0);
        end
        iv[0] = 1'b0;
        rel(0);
        ordy[0] = 1'b0;
        @(posedge clk); #1;
        chk("hold_no_accept", 32'(rdy[0]), 32'd1);

        // Reset in the middle of a conversion.
        bin[0] = 12'd3210;
        iv[0]  = 1'b1;
        acc    = 1'b0;
        for (int k = 0; k < 40 && !acc; k++) begin
            acc = rdy[0];
            @(posedge clk); #1;
        end
        iv[0] = 1'b0;
        chk("mid_accept", 32'(acc), 32'd1);
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ov",    32'(ov[0]),  32'd0);
        chk("mid_rst_bcd",   32'(bcd0),   32'h0000);
        chk("mid_rst_ready", 32'(rdy[0]), 32'd0);
        #10;
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("mid_rst_no_result", 32'(ov[0]), 32'd0);
        conv(0, 12'd801, 16'h0801, 1'b0, 1'b0, "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_iter.md
BIN_TO_BCD_ITER -- requirements
Module: bin_to_bcd_iter

Interface
REQ-001 The block SHALL have parameter ANCHO_BIN, default 12, meaning binary input width (legal 4..32).
REQ-002 The block SHALL have parameter DIGITOS, default 4, meaning number of BCD output digits (legal 1..10).
REQ-003 The block SHALL have parameter CON_SIGNO, default 0, meaning 0 = unsigned input, 1 = two's-complement input.
REQ-004 The block SHALL use one clock and an asynchronous active-low reset.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock (rising edge).
REQ-006 The block SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-007 The block SHALL have port binario, input, ANCHO_BIN bits, the value to convert, sampled on accept.
REQ-008 The block SHALL have port in_valid, input, 1 bit, meaning binario is valid.
REQ-009 The block SHALL have port in_ready, output, 1 bit, meaning the block can accept a value.
REQ-010 The block SHALL have port bcd, output, 4*DIGITOS bits, the packed BCD result with the least significant digit in [3:0].
REQ-011 The block SHALL have port signo, output, 1 bit, meaning the result is negative (always 0 when CON_SIGNO=0).
REQ-012 The block SHALL have port desborde, output, 1 bit, meaning the magnitude exceeds 10^DIGITOS-1.
REQ-013 The block SHALL have port out_valid, output, 1 bit, meaning bcd, signo and desborde hold a result.
REQ-014 The block SHALL have port out_ready, input, 1 bit, meaning the consumer takes the result.

Function
REQ-015 The block SHALL implement a three-state FSM: REPOSO (idle), CONVIERTE (converting) and LISTO (result held).
REQ-016 In REPOSO, in_ready SHALL be 1; in CONVIERTE and LISTO, in_ready SHALL be 0.
REQ-017 An accept SHALL occur at a rising edge where in_valid=1 and in_ready=1; binario SHALL be captured and the FSM SHALL move to CONVIERTE.
REQ-018 With CON_SIGNO=1, the block SHALL convert the magnitude |binario|, computed ANCHO_BIN bits wide, and set signo to the MSB of binario.
REQ-019 With CON_SIGNO=1, the most negative input (-2^(ANCHO_BIN-1)) SHALL convert to the correct magnitude 2^(ANCHO_BIN-1).
REQ-020 In CONVIERTE, each cycle SHALL add 3 to every BCD digit >= 5, then shift the magnitude MSB into bcd bit 0 (double-dabble), processing one bit per cycle, MSB first.
REQ-021 CONVIERTE SHALL last exactly ANCHO_BIN cycles, counted by an internal bit counter.
REQ-022 out_valid SHALL rise after the ANCHO_BIN-th rising edge following the accept edge.
REQ-023 The BCD shift register SHALL carry one extra guard digit beyond DIGITOS.
REQ-024 desborde SHALL be set if the guard digit is ever nonzero or a 1 is ever shifted out of it.
REQ-025 On overflow, bcd SHALL output the low DIGITOS digits of the result unchanged.
REQ-026 In LISTO, out_valid SHALL be 1, and bcd, signo and desborde SHALL be stable until out_ready=1.
REQ-027 A rising edge in LISTO with out_ready=1 SHALL return the FSM to REPOSO.
REQ-028 in_ready SHALL rise one cycle after the rising edge described in REQ-027; there SHALL be no same-cycle bypass.
REQ-029 in_valid SHALL be ignored outside REPOSO.
REQ-030 out_ready SHALL be ignored outside LISTO.
REQ-031 Throughput SHALL be one conversion per ANCHO_BIN+2 cycles when out_ready is held at 1.
REQ-032 bcd, signo and desborde SHALL be don't-care while out_valid=0, but SHALL NOT change in LISTO.

Reset
REQ-033 While rst_n=0, asynchronously, the FSM SHALL be REPOSO, the counter 0, bcd 0, signo 0, desborde 0 and out_valid 0.
REQ-034 While rst_n=0, in_ready SHALL be 0; in_ready SHALL be 1 from the first cycle after rst_n=1.
REQ-035 Reset asserted mid-CONVIERTE or in LISTO SHALL discard the conversion with no result emitted.

Verification
REQ-036 Default parameters, binario=4095 accepted, out_ready=1 -> out_valid rises 12 edges after accept; bcd=16'h4095, desborde=0.
REQ-037 Default parameters, binario=0, then binario=1, back-to-back -> results 16'h0000 and 16'h0001; the second accept occurs no sooner than 14 cycles after the first.
REQ-038 CON_SIGNO=1, ANCHO_BIN=12: binario=12'h800 -> bcd=16'h2048, signo=1; binario=12'hFFF -> bcd=16'h0001, signo=1.
REQ-039 DIGITOS=3, binario=1000 -> desborde=1, bcd=12'h000; binario=999 -> desborde=0, bcd=12'h999.
REQ-040 Hold out_ready=0 for 20 cycles in LISTO while toggling in_valid -> outputs stable, in_ready=0 and no new accept; the result is released on out_ready=1.
REQ-041 Assert rst_n=0 after 5 CONVIERTE cycles -> out_valid=0 and bcd=0 immediately; the next conversion after reset gives the correct result.
